// File: rtl/seg7_mux_disp.sv
// seg7_mux_disp: time-multiplexed hex display driver with overflow and leading-zero blanking
module seg7_mux_disp #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int LZ_BLANK    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    overflow,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    scan_tick
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] disp_q;
    logic                    ovf_q;
    logic [6:0]              seg_q, seg_d, dec;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic                    tick_q, term, blank;
    logic [3:0]              nib;

    // refresh counter, digit index and the digit pattern for the current index
    always_comb begin
        term    = cnt_q == CW'(REFRESH_DIV - 1);
        cnt_d   = term ? '0 : cnt_q + 1'b1;
        idx_d   = !term ? idx_q : (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        nib     = 4'(disp_q >> (4 * idx_q));
        blank   = LZ_BLANK != 0 && idx_q != '0 && (disp_q >> (4 * idx_q)) == '0;
        anode_d = ~(NUM_DIGITS'(1) << idx_q);
        seg_d   = ovf_q ? 7'b0110110 : blank ? 7'b1111111 : dec;
    end

    // hex to active-low {g,f,e,d,c,b,a}
    always_comb begin
        dec = 7'b1111111;
        case (nib)
            4'h0: dec = 7'b1000000;
            4'h1: dec = 7'b1111001;
            4'h2: dec = 7'b0100100;
            4'h3: dec = 7'b0110000;
            4'h4: dec = 7'b0011001;
            4'h5: dec = 7'b0010010;
            4'h6: dec = 7'b0000010;
            4'h7: dec = 7'b1111000;
            4'h8: dec = 7'b0000000;
            4'h9: dec = 7'b0010000;
            4'hA: dec = 7'b0001000;
            4'hB: dec = 7'b0000011;
            4'hC: dec = 7'b1000110;
            4'hD: dec = 7'b0100001;
            4'hE: dec = 7'b0000110;
            4'hF: dec = 7'b0001110;
        endcase
    end

    // scan state, display register and registered outputs; anode and seg share one stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            seg_q   <= 7'b1111111;
            anode_q <= '1;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            anode_q <= anode_d;
            tick_q  <= term;
            if (load) begin
                disp_q <= value;
                ovf_q  <= overflow;
            end
        end
    end

    assign seg       = seg_q;
    assign anode     = anode_q;
    assign scan_tick = tick_q;
endmodule

// File: tb/tb_seg7_mux_disp.sv
// tb_seg7_mux_disp: directed checks of a 4-digit/div-4 display and a 1-digit/div-2 display
module tb_seg7_mux_disp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load4 = 1'b0, ovf4 = 1'b0, load1 = 1'b0, ovf1 = 1'b0;
    logic [15:0] value4 = '0;
    logic [3:0]  value1 = '0;
    logic [6:0]  seg4, seg1;
    logic [3:0]  anode4;
    logic [0:0]  anode1;
    logic        tick4, tick1;
    int          cyc = 0, n_cmp = 0, n_err = 0;

    seg7_mux_disp #(.NUM_DIGITS(4), .REFRESH_DIV(4), .LZ_BLANK(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .load(load4), .value(value4), .overflow(ovf4),
        .seg(seg4), .anode(anode4), .scan_tick(tick4)
    );

    seg7_mux_disp #(.NUM_DIGITS(1), .REFRESH_DIV(2), .LZ_BLANK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load(load1), .value(value1), .overflow(ovf1),
        .seg(seg1), .anode(anode1), .scan_tick(tick1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        load4 = 1'b0;
        load1 = 1'b0;
    endtask

    // steps to the end of the current 16-cycle frame; first step shows first_seg (data not yet visible)
    task automatic frame(input logic [27:0] segs, input logic [6:0] first_seg, input string tag);
        int i0 = cyc % 16;
        for (int i = i0; i < 16; i++) begin
            logic [3:0] an_e;
            logic [6:0] sg_e;
            step();
            an_e = ~(4'b0001 << (i / 4));
            sg_e = (i == i0) ? first_seg : segs[7*(i/4) +: 7];
            check($sformatf("%s_anode_c%0d", tag, cyc), anode4, an_e);
            check($sformatf("%s_seg_c%0d", tag, cyc), seg4, sg_e);
            check($sformatf("%s_tick_c%0d", tag, cyc), tick4, i % 4 == 3);
        end
    endtask

    task automatic load_v(input logic [15:0] v, input logic o);
        value4 = v;
        ovf4   = o;
        load4  = 1'b1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_seg4", seg4, 7'b1111111);
        check("rst_anode4", anode4, 4'hF);
        check("rst_tick4", tick4, 1'b0);
        check("rst_seg1", seg1, 7'b1111111);
        check("rst_anode1", anode1, 1'b1);
        rst_n = 1'b1;
        cyc = 0;

        load_v(16'h12C4, 1'b0);
        frame({7'b1111001, 7'b0100100, 7'b1000110, 7'b0011001}, 7'b1000000, "f12c4");
        load_v(16'h000E, 1'b0);
        frame({7'b1111111, 7'b1111111, 7'b1111111, 7'b0000110}, 7'b0011001, "f000e");
        load_v(16'h0000, 1'b0);
        frame({7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 7'b0000110, "f0000");
        load_v(16'hFFFF, 1'b1);
        frame({4{7'b0110110}}, 7'b1000000, "fovf");
        load_v(16'hFFFF, 1'b0);
        frame({4{7'b0001110}}, 7'b0110110, "fffff");
        load_v(16'h12C4, 1'b0);
        frame({7'b1111001, 7'b0100100, 7'b1000110, 7'b0011001}, 7'b0001110, "f12c4b");

        while (cyc < 99) step();
        load_v(16'h5678, 1'b0);
        frame({7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}, 7'b0011001, "ftc");

        while (cyc < 117) step();
        load_v(16'h0B90, 1'b0);
        frame({7'b1111111, 7'b0000011, 7'b0010000, 7'b1000000}, 7'b1111000, "fmid");

        step();
        check("pre_rst_seg4", seg4, 7'b1000000);
        #2 rst_n = 1'b0;
        #1;
        check("async_seg4", seg4, 7'b1111111);
        check("async_anode4", anode4, 4'hF);
        check("async_tick4", tick4, 1'b0);
        check("async_seg1", seg1, 7'b1111111);
        check("async_anode1", anode1, 1'b1);
        step();
        check("held_seg4", seg4, 7'b1111111);
        check("held_anode4", anode4, 4'hF);
        value4 = 16'h1234;
        rst_n = 1'b1;
        cyc = 0;
        step();
        check("rel_seg4", seg4, 7'b1000000);
        check("rel_anode4", anode4, 4'b1110);
        check("rel_tick4", tick4, 1'b0);
        check("rel_seg1", seg1, 7'b1000000);
        check("rel_anode1", anode1, 1'b0);
        check("rel_tick1", tick1, 1'b0);

        value1 = 4'hA;
        load1  = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("d1_seg_c%0d", cyc), seg1, 7'b0001000);
            check($sformatf("d1_anode_c%0d", cyc), anode1, 1'b0);
            check($sformatf("d1_tick_c%0d", cyc), tick1, cyc % 2 == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
